frame_sequencer: RTL and testbench

- Per-frame controller for the graphics pipeline; replaces the ad-hoc timer/state logic in the top level.
- Generates a fixed frame tick, then pulses framebuffer switch/clear, waits for the clear to finish, and triggers view-matrix generation.
- Releases vertex fetch once the matrix is loaded and holds it in reset between frames.
- Reports frame, pixel and overrun statistics for the seven-segment debug display.

---
 rtl/gpu_ctrl_pkg.sv | 8 +
 rtl/frame_timer.sv | 15 +
 rtl/frame_sequencer.sv | 118 +++++++++++
 tb/tb_frame_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gpu_ctrl_pkg.sv
// gpu_ctrl_pkg: frame sequencer state encoding and shared saturating counter helper.
package gpu_ctrl_pkg;
  typedef enum logic [1:0] {WAIT_TICK, CLEAR, MATRIX, RENDER} frame_state_t;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: free-running 0..PERIOD-1 counter with a one-cycle tick on the last count.
module frame_timer #(
  parameter int PERIOD = 2_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  logic [TW-1:0] cnt_q;
  assign tick_out = (cnt_q == TW'(PERIOD - 1));
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) cnt_q <= '0;
    else cnt_q <= tick_out ? '0 : cnt_q + TW'(1);
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame switch/clear, matrix start and vertex-fetch release sequencing.
// Define FRAME_SEQ_STATS_EN to keep the pixel and overrun counters; otherwise both read 0.
module frame_sequencer
  import gpu_ctrl_pkg::*;
#(
  parameter int FRAME_PERIOD = 2_000_000,
  parameter int CLEAR_GUARD  = 100,
  parameter int MATRIX_COLS  = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             fb_ready_in,
  input  logic             matrix_valid_in,
  input  logic             pixel_valid_in,
  output logic             fb_switch_out,
  output logic             fb_clear_out,
  output logic             matrix_start_out,
  output logic             fetch_rst_out,
  output logic [CNT_W-1:0] frame_count_out,
  output logic [CNT_W-1:0] pixel_count_out,
  output logic [CNT_W-1:0] overrun_count_out
);
  localparam int GW = (CLEAR_GUARD > 0) ? $clog2(CLEAR_GUARD + 1) : 1;
  localparam int CW = (MATRIX_COLS > 1) ? $clog2(MATRIX_COLS) : 1;
  logic             tick;
  frame_state_t     state_q;
  logic [GW-1:0]    guard_q;
  logic [CW-1:0]    col_q;
  logic             switch_q, clear_q, mstart_q, fetch_rst_q;
  logic [CNT_W-1:0] frame_q;
`ifdef FRAME_SEQ_STATS_EN
  logic [CNT_W-1:0] pix_acc_q, pix_cnt_q, ovr_q;
  assign pixel_count_out   = pix_cnt_q;
  assign overrun_count_out = ovr_q;
`else
  logic unused_pixel_valid;
  assign unused_pixel_valid = pixel_valid_in;
  assign pixel_count_out    = '0;
  assign overrun_count_out  = '0;
`endif
  frame_timer #(.PERIOD(FRAME_PERIOD)) u_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tick_out(tick)
  );
  assign fb_switch_out    = switch_q;
  assign fb_clear_out     = clear_q;
  assign matrix_start_out = mstart_q;
  assign fetch_rst_out    = fetch_rst_q;
  assign frame_count_out  = frame_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= WAIT_TICK;
      guard_q     <= '0;
      col_q       <= '0;
      switch_q    <= 1'b0;
      clear_q     <= 1'b0;
      mstart_q    <= 1'b0;
      fetch_rst_q <= 1'b1;
      frame_q     <= '0;
`ifdef FRAME_SEQ_STATS_EN
      pix_acc_q   <= '0;
      pix_cnt_q   <= '0;
      ovr_q       <= '0;
`endif
    end else begin
      switch_q <= 1'b0;
      clear_q  <= 1'b0;
      mstart_q <= 1'b0;
      case (state_q)
        WAIT_TICK: if (tick) begin
          switch_q <= 1'b1;
          clear_q  <= 1'b1;
          guard_q  <= GW'(CLEAR_GUARD);
          state_q  <= CLEAR;
        end
        CLEAR: begin
          if (guard_q != '0) guard_q <= guard_q - GW'(1);
          else if (fb_ready_in) begin
            mstart_q <= 1'b1;
            col_q    <= '0;
            state_q  <= MATRIX;
          end
        end
        MATRIX: if (matrix_valid_in) begin
          if (col_q == CW'(MATRIX_COLS - 1)) begin
            fetch_rst_q <= 1'b0;
            state_q     <= RENDER;
`ifdef FRAME_SEQ_STATS_EN
            pix_acc_q   <= '0;
`endif
          end else col_q <= col_q + CW'(1);
        end
        RENDER: begin
`ifdef FRAME_SEQ_STATS_EN
          pix_acc_q <= sat_inc(pix_acc_q, pixel_valid_in);
`endif
          if (tick) begin
`ifdef FRAME_SEQ_STATS_EN
            pix_cnt_q <= sat_inc(pix_acc_q, pixel_valid_in);
`endif
            frame_q     <= frame_q + CNT_W'(1);
            fetch_rst_q <= 1'b1;
            switch_q    <= 1'b1;
            clear_q     <= 1'b1;
            guard_q     <= GW'(CLEAR_GUARD);
            state_q     <= CLEAR;
          end
        end
        default: state_q <= WAIT_TICK;
      endcase
`ifdef FRAME_SEQ_STATS_EN
      // a tick landing mid-sequence is dropped; only its occurrence is recorded
      if (tick && (state_q == CLEAR || state_q == MATRIX)) ovr_q <= sat_inc(ovr_q, 1'b1);
`endif
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed table plus hand sequences for frame_sequencer (period 200, guard 10, 4 cols).
module tb_frame_sequencer;
`ifdef FRAME_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, mv = 1'b0, pv = 1'b0;
  logic sw, clr, ms, frst;
  logic [15:0] frame, pix, ovr;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct {
    int cyc;
    logic rdy, mv, pv;
    logic sw, clr, ms, frst;
    logic [15:0] frame;
  } vec_t;
  vec_t tv[$];
  frame_sequencer #(.FRAME_PERIOD(200), .CLEAR_GUARD(10), .MATRIX_COLS(4)) dut (
    .clk_in(clk), .rst_in(rst), .fb_ready_in(rdy), .matrix_valid_in(mv), .pixel_valid_in(pv),
    .fb_switch_out(sw), .fb_clear_out(clr), .matrix_start_out(ms), .fetch_rst_out(frst),
    .frame_count_out(frame), .pixel_count_out(pix), .overrun_count_out(ovr)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic run_to(input int n);
    while (cyc < n) begin
      step();
      mv = 1'b0;
      pv = 1'b0;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    mv = 1'b0;
    pv = 1'b0;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask
  task automatic add(input int c, input logic r, m, p, s, cl, st, f, input logic [15:0] fr);
    vec_t v;
    v.cyc = c; v.rdy = r; v.mv = m; v.pv = p;
    v.sw = s; v.clr = cl; v.ms = st; v.frst = f; v.frame = fr;
    tv.push_back(v);
  endtask
  initial begin
    //   cyc  rdy  mv   pv   sw   clr  ms   frst frame
    add(0,   1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(199, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(200, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,16'd0);
    add(201, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(202, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(203, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(205, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(210, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(211, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'd0);
    add(212, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(213, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(214, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(216, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(218, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0);
    add(219, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0);
    do_reset();
    chk("reset_pix", pix, 16'd0);
    chk("reset_ovr", ovr, 16'd0);
    foreach (tv[i]) begin
      run_to(tv[i].cyc);
      chk($sformatf("tv%0d_switch", i), {15'd0, sw}, {15'd0, tv[i].sw});
      chk($sformatf("tv%0d_clear", i), {15'd0, clr}, {15'd0, tv[i].clr});
      chk($sformatf("tv%0d_mstart", i), {15'd0, ms}, {15'd0, tv[i].ms});
      chk($sformatf("tv%0d_fetch_rst", i), {15'd0, frst}, {15'd0, tv[i].frst});
      chk($sformatf("tv%0d_frame", i), frame, tv[i].frame);
      rdy = tv[i].rdy;
      mv = tv[i].mv;
      pv = tv[i].pv;
    end
    for (int i = 0; i < 36; i++) begin
      run_to(220 + i);
      pv = 1'b1;
    end
    run_to(399);
    chk("pre_tick_frame", frame, 16'd0);
    chk("pre_tick_fetch_rst", {15'd0, frst}, 16'd0);
    pv = 1'b1;
    run_to(400);
    chk("tick1_switch", {15'd0, sw}, 16'd1);
    chk("tick1_clear", {15'd0, clr}, 16'd1);
    chk("tick1_frame", frame, 16'd1);
    chk("tick1_fetch_rst", {15'd0, frst}, 16'd1);
    chk("tick1_pix", pix, STATS ? 16'd37 : 16'd0);
    rdy = 1'b0;
    run_to(600);
    chk("ovr_clear_switch", {15'd0, sw}, 16'd0);
    chk("ovr_clear_mstart", {15'd0, ms}, 16'd0);
    chk("ovr_clear_count", ovr, STATS ? 16'd1 : 16'd0);
    chk("ovr_clear_frame", frame, 16'd1);
    rdy = 1'b1;
    run_to(601);
    chk("late_mstart", {15'd0, ms}, 16'd1);
    run_to(602); mv = 1'b1;
    run_to(604); mv = 1'b1;
    run_to(606); mv = 1'b1;
    run_to(700);
    chk("three_cols_fetch_rst", {15'd0, frst}, 16'd1);
    run_to(800);
    chk("ovr_matrix_switch", {15'd0, sw}, 16'd0);
    chk("ovr_matrix_count", ovr, STATS ? 16'd2 : 16'd0);
    chk("ovr_matrix_fetch_rst", {15'd0, frst}, 16'd1);
    mv = 1'b1;
    run_to(801);
    chk("fourth_col_release", {15'd0, frst}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      run_to(802 + i);
      pv = 1'b1;
    end
    run_to(850);
    chk("pre_rst_frame", frame, 16'd1);
    chk("pre_rst_pix", pix, STATS ? 16'd37 : 16'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_fetch_rst", {15'd0, frst}, 16'd1);
    chk("async_rst_frame", frame, 16'd0);
    chk("async_rst_pix", pix, 16'd0);
    chk("async_rst_ovr", ovr, 16'd0);
    chk("async_rst_switch", {15'd0, sw}, 16'd0);
    do_reset();
    run_to(211);
    chk("f2_mstart", {15'd0, ms}, 16'd1);
    run_to(212); mv = 1'b1;
    run_to(213); mv = 1'b1;
    run_to(214); mv = 1'b1;
    run_to(215); mv = 1'b1;
    run_to(216);
    chk("f2_release", {15'd0, frst}, 16'd0);
    run_to(250);
    force dut.frame_q = 16'hFFFF;
`ifdef FRAME_SEQ_STATS_EN
    force dut.pix_acc_q = 16'hFFFE;
`endif
    #1;
    release dut.frame_q;
`ifdef FRAME_SEQ_STATS_EN
    release dut.pix_acc_q;
`endif
    chk("forced_frame", frame, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      run_to(250 + i);
      pv = 1'b1;
    end
    run_to(400);
    chk("wrap_frame", frame, 16'd0);
    chk("sat_pix", pix, STATS ? 16'hFFFF : 16'd0);
    chk("wrap_switch", {15'd0, sw}, 16'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
